// File: rtl/bs_mac_pe_if.sv
`default_nettype none
// ============================================================================
// Module   : bs_mac_pe_if
// Brief    : Control, operand and serial partial-sum signals of one bs_mac_pe.
// Revision : 1.0
// ============================================================================
interface bs_mac_pe_if #(
    parameter int W_WIDTH = 8
);
    logic               w_load;
    logic               w_in;
    logic [W_WIDTH-1:0] shared_w;
    logic               act_valid;
    logic               act_bit;
    logic               act_last;
    logic               clear_acc;
    logic               drain;
    logic               sum_in;
    logic               sum_out;
    logic               sum_out_valid;
    logic               done;
    logic               busy;
    logic               ovf;

    modport master (
        output w_load, w_in, shared_w, act_valid, act_bit, act_last,
               clear_acc, drain, sum_in,
        input  sum_out, sum_out_valid, done, busy, ovf
    );

    modport slave (
        input  w_load, w_in, shared_w, act_valid, act_bit, act_last,
               clear_acc, drain, sum_in,
        output sum_out, sum_out_valid, done, busy, ovf
    );
endinterface
`default_nettype wire

// File: rtl/bs_mac_pe.sv
`default_nettype none
// ============================================================================
// Module   : bs_mac_pe
// Brief    : Bit-serial signed MAC processing element with chained serial drain.
// Revision : 1.0
// ============================================================================
module bs_mac_pe #(
    parameter int                   W_WIDTH          = 8,
    parameter int                   A_WIDTH          = 8,
    parameter int                   ACC_WIDTH        = 24,
    parameter int                   SIGNED_A         = 1,
    parameter int                   SHARED_W         = 0,
    parameter logic [W_WIDTH-1:0]   WEIGHT_RESET_VAL = W_WIDTH'(8'h23)
) (
    input  wire logic       clk,
    input  wire logic       reset_n,
    bs_mac_pe_if.slave      bus
);
    localparam int K_W = (A_WIDTH > 1) ? $clog2(A_WIDTH) : 1;
    localparam int D_W = (ACC_WIDTH > 1) ? $clog2(ACC_WIDTH) : 1;
    localparam logic [K_W-1:0] c_K_MAX = K_W'(A_WIDTH - 1);
    localparam logic [D_W-1:0] c_D_MAX = D_W'(ACC_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [W_WIDTH-1:0]     r_weight;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [K_W-1:0]         r_k;
    logic [D_W-1:0]         r_dcnt;
    logic                   r_carry;
    logic                   r_sum_out;
    logic                   r_sum_out_valid;
    logic                   r_done;
    logic                   r_busy;
    logic                   r_ovf;

    logic [W_WIDTH-1:0]     w_weight;
    logic [ACC_WIDTH-1:0]   w_w_ext;
    logic [ACC_WIDTH-1:0]   w_w_shift;
    logic [ACC_WIDTH-1:0]   w_sum;
    logic [ACC_WIDTH-1:0]   w_diff;
    logic                   w_is_msb;
    logic                   w_mac_en;
    logic                   w_do_sub;
    logic                   w_do_add;
    logic                   w_add_ovf;
    logic                   w_sub_ovf;
    logic                   w_drain_go;
    logic                   w_drain_last;
    logic                   w_load_ok;

    assign w_weight  = (SHARED_W != 0) ? bus.shared_w : r_weight;
    assign w_w_ext   = {{(ACC_WIDTH-W_WIDTH){w_weight[W_WIDTH-1]}}, w_weight};
    assign w_w_shift = w_w_ext << r_k;
    assign w_sum     = r_acc + w_w_shift;
    assign w_diff    = r_acc - w_w_shift;

    // Operand MSB is either flagged explicitly or implied by the maximum width.
    assign w_is_msb  = bus.act_last || (r_k == c_K_MAX);
    assign w_mac_en  = bus.act_valid && (r_state != S_DRAIN);
    assign w_do_sub  = w_is_msb && (SIGNED_A != 0) && bus.act_bit;
    assign w_do_add  = bus.act_bit && !w_do_sub;

    assign w_add_ovf = (r_acc[ACC_WIDTH-1] == w_w_shift[ACC_WIDTH-1]) &&
                       (w_sum[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);
    assign w_sub_ovf = (r_acc[ACC_WIDTH-1] != w_w_shift[ACC_WIDTH-1]) &&
                       (w_diff[ACC_WIDTH-1] != r_acc[ACC_WIDTH-1]);

    assign w_drain_go   = (r_state == S_IDLE) && bus.drain && !bus.act_valid;
    assign w_drain_last = (r_state == S_DRAIN) && (r_dcnt == c_D_MAX);
    assign w_load_ok    = (SHARED_W == 0) && bus.w_load &&
                          (r_state == S_IDLE) && !bus.act_valid;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.act_valid) begin
                    if (!w_is_msb) w_state_nxt = S_MAC;
                end else if (bus.drain) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_MAC: begin
                if (bus.act_valid && w_is_msb) w_state_nxt = S_IDLE;
            end
            S_DRAIN: begin
                if (w_drain_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (bus.clear_acc) w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)       r_weight <= WEIGHT_RESET_VAL;
        else if (w_load_ok) r_weight <= {bus.w_in, r_weight[W_WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_acc           <= '0;
            r_k             <= '0;
            r_dcnt          <= '0;
            r_carry         <= 1'b0;
            r_sum_out       <= 1'b0;
            r_sum_out_valid <= 1'b0;
            r_done          <= 1'b0;
            r_busy          <= 1'b0;
            r_ovf           <= 1'b0;
        end else begin
            r_sum_out_valid <= 1'b0;
            r_done          <= 1'b0;
            r_busy          <= (w_state_nxt != S_IDLE);
            if (bus.clear_acc) begin
                r_acc     <= '0;
                r_k       <= '0;
                r_dcnt    <= '0;
                r_carry   <= 1'b0;
                r_ovf     <= 1'b0;
                r_sum_out <= 1'b0;
            end else begin
                if (w_mac_en) begin
                    if (w_do_sub) begin
                        r_acc <= w_diff;
                        r_ovf <= r_ovf | w_sub_ovf;
                    end else if (w_do_add) begin
                        r_acc <= w_sum;
                        r_ovf <= r_ovf | w_add_ovf;
                    end
                    r_k <= w_is_msb ? '0 : r_k + K_W'(1);
                end
                if (w_drain_go) begin
                    r_carry <= 1'b0;
                    r_dcnt  <= '0;
                end
                // Accumulator shifts right while draining, so bit 0 is always the next bit out.
                if (r_state == S_DRAIN) begin
                    r_sum_out       <= r_acc[0] ^ bus.sum_in ^ r_carry;
                    r_carry         <= (r_acc[0] & bus.sum_in) | (r_acc[0] & r_carry) |
                                       (bus.sum_in & r_carry);
                    r_sum_out_valid <= 1'b1;
                    r_acc           <= r_acc >> 1;
                    r_dcnt          <= r_dcnt + D_W'(1);
                    if (w_drain_last) begin
                        r_done <= 1'b1;
                        r_acc  <= '0;
                        r_ovf  <= 1'b0;
                        r_dcnt <= '0;
                    end
                end
            end
        end
    end

    assign bus.sum_out       = r_sum_out;
    assign bus.sum_out_valid = r_sum_out_valid;
    assign bus.done          = r_done;
    assign bus.busy          = r_busy;
    assign bus.ovf           = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_bs_mac_pe.sv
`default_nettype none
// ============================================================================
// Module   : tb_bs_mac_pe
// Brief    : Directed bench for bs_mac_pe (24-bit and 16-bit accumulator builds).
// Revision : 1.0
// ============================================================================
module tb_bs_mac_pe;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic w_load = 1'b0, w_in = 1'b0, act_valid = 1'b0, act_bit = 1'b0;
    logic act_last = 1'b0, clear_acc = 1'b0, drain = 1'b0, sum_in = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    bs_mac_pe_if #(.W_WIDTH(8)) b24 ();
    bs_mac_pe_if #(.W_WIDTH(8)) b16 ();

    assign b24.w_load = w_load;       assign b16.w_load = w_load;
    assign b24.w_in = w_in;           assign b16.w_in = w_in;
    assign b24.shared_w = 8'h00;      assign b16.shared_w = 8'h00;
    assign b24.act_valid = act_valid; assign b16.act_valid = act_valid;
    assign b24.act_bit = act_bit;     assign b16.act_bit = act_bit;
    assign b24.act_last = act_last;   assign b16.act_last = act_last;
    assign b24.clear_acc = clear_acc; assign b16.clear_acc = clear_acc;
    assign b24.drain = drain;         assign b16.drain = drain;
    assign b24.sum_in = sum_in;       assign b16.sum_in = sum_in;

    bs_mac_pe #(.ACC_WIDTH(24)) u_dut24 (.clk(clk), .reset_n(reset_n), .bus(b24));
    bs_mac_pe #(.ACC_WIDTH(16)) u_dut16 (.clk(clk), .reset_n(reset_n), .bus(b16));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            w_load = 1'b1;
            w_in   = v[i];
            step();
        end
        w_load = 1'b0;
        w_in   = 1'b0;
    endtask

    // Eight-bit operand LSB-first; optional drain / w_load pulse at bit index.
    task automatic send_act(input logic [7:0] v, input int drain_at, input int wl_at);
        for (int i = 0; i < 8; i++) begin
            act_valid = 1'b1;
            act_bit   = v[i];
            act_last  = (i == 7);
            drain     = (i == drain_at);
            w_load    = (i == wl_at);
            w_in      = 1'b1;
            step();
        end
        act_valid = 1'b0; act_bit = 1'b0; act_last = 1'b0;
        drain = 1'b0; w_load = 1'b0; w_in = 1'b0;
    endtask

    task automatic do_drain(input string tag, input int n, input logic [23:0] sin,
                            input logic [23:0] exp);
        logic [23:0] got;
        int          vcnt;
        int          dpos;
        got  = '0;
        vcnt = 0;
        dpos = -1;
        drain = 1'b1;
        step();
        drain = 1'b0;
        check({tag, "_busy"}, (n == 16) ? b16.busy : b24.busy, 1);
        for (int i = 0; i < n; i++) begin
            sum_in = sin[i];
            step();
            if ((n == 16) ? b16.sum_out_valid : b24.sum_out_valid) begin
                got[i] = (n == 16) ? b16.sum_out : b24.sum_out;
                vcnt++;
            end
            if ((n == 16) ? b16.done : b24.done) dpos = i;
        end
        sum_in = 1'b0;
        check({tag, "_val"}, got, exp);
        check({tag, "_vcnt"}, vcnt, n);
        check({tag, "_done"}, dpos, n - 1);
        check({tag, "_busy_end"}, (n == 16) ? b16.busy : b24.busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        step(); step();
        check("reset_outs", {b24.sum_out, b24.sum_out_valid, b24.done, b24.busy, b24.ovf}, 0);
        reset_n = 1'b1;

        // Reset weight 0x23 times 1
        send_act(8'h01, -1, -1);
        do_drain("w_reset", 24, 24'd0, 24'h000023);

        // Serial weight load
        load_w(8'h5A);
        send_act(8'h01, -1, -1);
        do_drain("w_load", 24, 24'd0, 24'h00005A);

        // W=3, act=-5, with a stray w_load during MAC
        load_w(8'h03);
        send_act(8'hFB, -1, 3);
        check("signed_ovf", b24.ovf, 0);
        do_drain("signed", 24, 24'd0, 24'hFFFFF1);

        // W=-2, 10 and 7 back-to-back, chained sum_in=100
        load_w(8'hFE);
        send_act(8'd10, -1, -1);
        send_act(8'd7, -1, -1);
        do_drain("chain", 24, 24'd100, 24'h000042);

        // Drain mid-operand is ignored: -2*5
        send_act(8'd5, 3, -1);
        check("mid_drain_busy", b24.sum_out_valid, 0);
        do_drain("mid_drain", 24, 24'd0, 24'hFFFFF6);

        // Drain with act_valid in IDLE: MAC wins: -2*3
        send_act(8'd3, 0, -1);
        step();
        check("both_noval", {b24.sum_out_valid, b24.busy}, 0);
        do_drain("both", 24, 24'd0, 24'hFFFFFA);

        // clear_acc at drain bit 5
        send_act(8'h01, -1, -1);
        drain = 1'b1;
        step();
        drain = 1'b0;
        for (int i = 0; i < 6; i++) begin
            clear_acc = (i == 5);
            step();
        end
        clear_acc = 1'b0;
        check("clr_state", {b24.sum_out_valid, b24.done, b24.busy, b24.ovf}, 0);
        do_drain("clr_acc", 24, 24'd0, 24'h000000);

        // Overflow on the 16-bit build: 127 * -128, three times
        clear_acc = 1'b1;
        step();
        clear_acc = 1'b0;
        load_w(8'h7F);
        send_act(8'h80, -1, -1);
        send_act(8'h80, -1, -1);
        send_act(8'h80, -1, -1);
        check("ovf16_set", b16.ovf, 1);
        check("ovf24_clr", b24.ovf, 0);
        do_drain("ovf16", 16, 24'd0, 24'h004180);
        check("ovf16_after", b16.ovf, 0);
        for (int i = 0; i < 10; i++) step();

        // Reset mid-MAC
        send_act(8'h01, -1, -1);
        act_valid = 1'b1; act_bit = 1'b1;
        step(); step(); step();
        reset_n = 1'b0;
        act_valid = 1'b0; act_bit = 1'b0;
        step();
        check("rst_mid", {b24.sum_out, b24.sum_out_valid, b24.done, b24.busy, b24.ovf}, 0);
        reset_n = 1'b1;
        send_act(8'h01, -1, -1);
        do_drain("rst_w", 24, 24'd0, 24'h000023);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/bs_mac_pe.md
# bs_mac_pe

Parametrised bit-serial multiply-accumulate processing element for the systolic array. Generalises the existing 8-bit serial MAC cell:
- configurable weight, activation and accumulator widths;
- signed (two's-complement) activations;
- an internal bit counter and FSM in place of external phase controls;
- a serial drain path that adds an upstream partial-sum stream, so PEs chain down a column with one cycle of latency each.

## Interface
- W_WIDTH, 8, weight width in bits.
- A_WIDTH, 8, maximum activation width in bits.
- ACC_WIDTH, 24, accumulator width; must be ≥ W_WIDTH+A_WIDTH.
- SIGNED_A, 1, 1 = activation MSB has negative weight; 0 = unsigned activations.
- SHARED_W, 0, 1 = weight taken from shared_w; 0 = local serially loaded register.
- WEIGHT_RESET_VAL, 8'h23 (resized to W_WIDTH), local weight value after reset.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- w_load  in  1  shift one weight bit in.
- w_in  in  1  weight bit, LSB-first; shifts into the MSB, register shifts right.
- shared_w  in  W_WIDTH  signed weight, used when SHARED_W=1.
- act_valid  in  1  act_bit is valid this cycle.
- act_bit  in  1  activation bit, LSB-first.
- act_last  in  1  qualifies act_bit as the operand MSB.
- clear_acc  in  1  synchronous clear of the accumulator state.
- drain  in  1  request a serial readout.
- sum_in  in  1  upstream partial-sum bit, LSB-first.
- sum_out  out  1  registered serial sum, LSB-first.
- sum_out_valid  out  1  sum_out carries a valid bit.
- done  out  1  one-cycle pulse with the last drained bit.
- busy  out  1  high in MAC or DRAIN.
- ovf  out  1  sticky signed-overflow flag on accumulator updates.

## Operation
- The weight is always signed and sign-extended to ACC_WIDTH.
- Internal state:
  - bit counter k, width clog2(A_WIDTH);
  - acc, ACC_WIDTH bits;
  - drain counter;
  - carry flop;
  - FSM with states IDLE, MAC and DRAIN.
- **IDLE** (k==0):
  - act_valid moves to MAC, unless act_last is also set; a single-bit operand stays in IDLE.
  - drain with act_valid low moves to DRAIN.
  - drain and act_valid together: act_valid wins and drain is dropped.
- **MAC**:
  - Each act_valid bit b at index k does acc += b ? (W<<k) : 0.
  - If the bit is the MSB and SIGNED_A=1, it does acc −= W<<k instead.
  - The MSB is the bit with act_last set, or index A_WIDTH−1, whichever comes first.
  - After the MSB, k returns to 0 and the FSM returns to IDLE.
  - Cycles with act_valid low hold all state.
  - drain is ignored in MAC.
- **DRAIN**, one cycle per bit i, for i = 0..ACC_WIDTH−1:
  - sum_out <= acc[i] ^ sum_in ^ c;
  - c <= majority(acc[i], sum_in, c).
  - c is cleared on DRAIN entry.
  - act_valid is ignored in DRAIN.
  - After bit ACC_WIDTH−1: acc and ovf clear and the FSM returns to IDLE.
- **w_load**:
  - Accepted only in IDLE with act_valid low; ignored otherwise.
  - Ignored entirely when SHARED_W=1.
- **clear_acc**:
  - Priority below reset, above everything else.
  - Clears acc, ovf, k, c and the drain counter.
  - Forces the FSM to IDLE and sum_out_valid/done low the next cycle.
  - Weight is unaffected.
- **Overflow**:
  - acc wraps modulo 2^ACC_WIDTH.
  - ovf sets when a signed add or subtract overflows and stays set until clear_acc, drain completion or reset.
- **Reset values**:
  - sum_out, sum_out_valid, done, busy, ovf, acc, k: all 0.
  - State: IDLE.
  - Local weight: WEIGHT_RESET_VAL.

## Timing
- acc updates on the edge ending the act_valid cycle; ovf updates on the same edge.
- An A_WIDTH-bit operand takes A_WIDTH act_valid cycles. Back-to-back operands are allowed: the next operand's LSB may arrive the cycle after act_last.
- Drain accepted in cycle t:
  - DRAIN occupies cycles t+1 .. t+ACC_WIDTH;
  - sum_in bit i is sampled in cycle t+1+i;
  - sum_out bit i is presented in cycle t+2+i with sum_out_valid high;
  - done is high in cycle t+1+ACC_WIDTH.
- Per-PE chain latency is 1 cycle, so a downstream PE's drain must start 1 cycle after its upstream PE's.
- A new act_valid is accepted in cycle t+ACC_WIDTH+1 or later.
- busy is registered with the state and is high from cycle t+1 through t+ACC_WIDTH.
- Reset asserted mid-operation, in any state: all outputs are at reset values the following cycle, and any partial drain is lost.

## Test plan
- Weight load: 8 w_load cycles carrying 0x5A LSB-first -> W=0x5A; a w_load pulse during MAC leaves W unchanged.
- Signed product: W=3, activation −5 (8'hFB LSB-first, act_last on bit 7), drain with sum_in=0 -> sum_out stream 24'hFFFFF1; done on the 24th bit; ovf=0.
- Accumulate and chain: W=−2 (8'hFE), activations 10 then 7 back-to-back, drain with sum_in = serial 100 -> 24'h000042; sum_out lags sum_in by 1 cycle.
- Overflow: ACC_WIDTH=16, W=127, three activations of −128 -> ovf=1, drained value 16'h4180 (16768).
- Arbitration: drain asserted at k=3 mid-operand -> ignored, acc correct after act_last. drain together with act_valid in IDLE -> MAC, no drain.
- Aborts: clear_acc at drain bit 5 -> sum_out_valid low the next cycle, acc=0, IDLE. reset_n low mid-MAC -> all outputs 0 and W=WEIGHT_RESET_VAL the next cycle.
